// File: rtl/mem_fill_pkg.sv
// Shared constants for the memory fill arbiter: FSM encoding and width helpers.
package mem_fill_pkg;

   localparam int unsigned ST_W = 2;

   localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
   localparam logic [ST_W-1:0] ST_WRITE = 2'd1;
   localparam logic [ST_W-1:0] ST_FILL  = 2'd2;

   // Ceiling log2; returns 0 for v <= 1.
   function automatic int unsigned clog2_fn(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   // Ceiling log2 clamped to at least one bit, for index vectors.
   function automatic int unsigned clog2_min1(input int unsigned v);
      return (clog2_fn(v) == 0) ? 1 : clog2_fn(v);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: first requester at or above ptr, wrapping to the lowest.
module rr_arbiter
   import mem_fill_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0]             req,
   input  logic [clog2_min1(NUM_REQ)-1:0] ptr,
   output logic [NUM_REQ-1:0]             grant,
   output logic                           valid
);

   localparam int unsigned PTR_W = clog2_min1(NUM_REQ);

   logic found;

   // Upper pass covers [ptr, NUM_REQ-1]; lower pass wraps around from 0.
   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!found && req[i] && (PTR_W'(i) >= ptr)) begin
            grant[i] = 1'b1;
            found    = 1'b1;
         end
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!found && req[i]) begin
            grant[i] = 1'b1;
            found    = 1'b1;
         end
      end
   end

   assign valid = |req;

endmodule

// File: rtl/mem_fill_arbiter.sv
// Shares one pipelined memory between cache channels: write-through writes
// first, then block fills, each chosen round-robin.
module mem_fill_arbiter
   import mem_fill_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned WPB     = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        miss,
   input  logic [NUM_REQ*ADDR_W-1:0] miss_addr,
   input  logic [NUM_REQ-1:0]        wr_req,
   input  logic [NUM_REQ*ADDR_W-1:0] wr_addr,
   input  logic [NUM_REQ*DATA_W-1:0] wr_data,
   output logic [NUM_REQ-1:0]        wr_ack,
   output logic [NUM_REQ-1:0]        stall,
   output logic [NUM_REQ-1:0]        fill_data_we,
   output logic [NUM_REQ-1:0]        fill_tag_we,
   output logic [clog2_fn(WPB)-1:0]  fill_word,
   output logic [DATA_W-1:0]         fill_data,
   output logic                      mem_en,
   output logic                      mem_wr,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic [DATA_W-1:0]         mem_rdata,
   input  logic                      mem_rvalid
);

   localparam int unsigned WORD_W = clog2_fn(WPB);
   localparam int unsigned CNT_W  = WORD_W + 1;
   localparam int unsigned PTR_W  = clog2_min1(NUM_REQ);
   // Block base: clear word index plus the byte-in-word bit.
   localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(2 * WPB - 1);

   logic [ST_W-1:0]    state_q, state_nx;
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_nx;
   logic [PTR_W-1:0]   owner_q, owner_nx;
   logic [ADDR_W-1:0]  base_q, base_nx;
   logic [CNT_W-1:0]   issue_q, issue_nx;
   logic [CNT_W-1:0]   ret_q, ret_nx;

   logic               mem_en_nx, mem_wr_nx;
   logic [ADDR_W-1:0]  mem_addr_nx;
   logic [DATA_W-1:0]  mem_wdata_nx, fill_data_nx;
   logic [NUM_REQ-1:0] wr_ack_nx, data_we_nx, tag_we_nx;
   logic [WORD_W-1:0]  fill_word_nx;

   logic [NUM_REQ-1:0] arb_req, arb_grant, owner_hot;
   logic               arb_valid;
   logic [PTR_W-1:0]   arb_idx, next_ptr;
   logic [ADDR_W-1:0]  sel_waddr, sel_maddr;
   logic [DATA_W-1:0]  sel_wdata;

   // Writes outrank misses, so the arbiter sees whichever class is pending.
   assign arb_req = (|wr_req) ? wr_req : miss;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr (
      .req   (arb_req),
      .ptr   (rr_ptr_q),
      .grant (arb_grant),
      .valid (arb_valid)
   );

   // Encode the one-hot grant and pick the winner's address/data.
   always_comb begin
      arb_idx   = '0;
      sel_waddr = '0;
      sel_wdata = '0;
      sel_maddr = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (arb_grant[i]) begin
            arb_idx   = PTR_W'(i);
            sel_waddr = wr_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = wr_data[i*DATA_W +: DATA_W];
            sel_maddr = miss_addr[i*ADDR_W +: ADDR_W];
         end
      end
   end

   assign next_ptr = (arb_idx == PTR_W'(NUM_REQ - 1)) ? '0 : arb_idx + PTR_W'(1);

   // Per-channel owner decode and pipeline hold.
   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         owner_hot[i] = (owner_q == PTR_W'(i));
         stall[i]     = miss[i] | (wr_req[i] & ~wr_ack[i]) |
                        ((state_q == ST_FILL) & owner_hot[i]);
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nx     = state_q;
      rr_ptr_nx    = rr_ptr_q;
      owner_nx     = owner_q;
      base_nx      = base_q;
      issue_nx     = issue_q;
      ret_nx       = ret_q;
      mem_en_nx    = 1'b0;
      mem_wr_nx    = 1'b0;
      mem_addr_nx  = '0;
      mem_wdata_nx = '0;
      wr_ack_nx    = '0;
      data_we_nx   = '0;
      tag_we_nx    = '0;
      fill_word_nx = '0;
      fill_data_nx = '0;
      case (state_q)
         ST_IDLE: begin
            if (arb_valid) begin
               rr_ptr_nx = next_ptr;
               if (|wr_req) begin
                  state_nx     = ST_WRITE;
                  mem_en_nx    = 1'b1;
                  mem_wr_nx    = 1'b1;
                  mem_addr_nx  = sel_waddr;
                  mem_wdata_nx = sel_wdata;
                  wr_ack_nx    = arb_grant;
               end else begin
                  // First fill issue goes out with the state change.
                  state_nx    = ST_FILL;
                  owner_nx    = arb_idx;
                  base_nx     = sel_maddr & BASE_MASK;
                  mem_en_nx   = 1'b1;
                  mem_addr_nx = sel_maddr & BASE_MASK;
                  issue_nx    = CNT_W'(1);
                  ret_nx      = '0;
               end
            end
         end
         ST_WRITE: begin
            state_nx = ST_IDLE;
         end
         ST_FILL: begin
            if (issue_q < CNT_W'(WPB)) begin
               mem_en_nx   = 1'b1;
               mem_addr_nx = base_q + (ADDR_W'(issue_q) << 1);
               issue_nx    = issue_q + CNT_W'(1);
            end
            if (mem_rvalid) begin
               data_we_nx   = owner_hot;
               fill_word_nx = WORD_W'(ret_q);
               fill_data_nx = mem_rdata;
               ret_nx       = ret_q + CNT_W'(1);
               if (ret_q == CNT_W'(WPB - 1)) begin
                  tag_we_nx = owner_hot;
                  state_nx  = ST_IDLE;
                  issue_nx  = '0;
                  ret_nx    = '0;
               end
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         rr_ptr_q     <= '0;
         owner_q      <= '0;
         base_q       <= '0;
         issue_q      <= '0;
         ret_q        <= '0;
         mem_en       <= 1'b0;
         mem_wr       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         wr_ack       <= '0;
         fill_data_we <= '0;
         fill_tag_we  <= '0;
         fill_word    <= '0;
         fill_data    <= '0;
      end else begin
         state_q      <= state_nx;
         rr_ptr_q     <= rr_ptr_nx;
         owner_q      <= owner_nx;
         base_q       <= base_nx;
         issue_q      <= issue_nx;
         ret_q        <= ret_nx;
         mem_en       <= mem_en_nx;
         mem_wr       <= mem_wr_nx;
         mem_addr     <= mem_addr_nx;
         mem_wdata    <= mem_wdata_nx;
         wr_ack       <= wr_ack_nx;
         fill_data_we <= data_we_nx;
         fill_tag_we  <= tag_we_nx;
         fill_word    <= fill_word_nx;
         fill_data    <= fill_data_nx;
      end
   end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Directed bench for mem_fill_arbiter with latency-4 memory models.
module tb_mem_fill_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   int          n_cmp = 0;
   int          n_err = 0;

   // Default instance: NUM_REQ=2, WPB=8
   logic [1:0]  miss, wr_req, wr_ack, stall, fill_data_we, fill_tag_we;
   logic [31:0] miss_addr, wr_addr, wr_data;
   logic [2:0]  fill_word;
   logic [15:0] fill_data, mem_addr, mem_wdata, mem_rdata;
   logic        mem_en, mem_wr, mem_rvalid;

   // Second instance: NUM_REQ=4, WPB=4
   logic [3:0]  miss4, wr_req4, wr_ack4, stall4, we4, tag4;
   logic [63:0] miss_addr4, wr_addr4, wr_data4;
   logic [1:0]  word4;
   logic [15:0] data4, addr4, wdata4, rdata4;
   logic        en4, wr4, rvalid4;

   mem_fill_arbiter dut (
      .clk (clk), .rst (rst), .miss (miss), .miss_addr (miss_addr),
      .wr_req (wr_req), .wr_addr (wr_addr), .wr_data (wr_data),
      .wr_ack (wr_ack), .stall (stall), .fill_data_we (fill_data_we),
      .fill_tag_we (fill_tag_we), .fill_word (fill_word), .fill_data (fill_data),
      .mem_en (mem_en), .mem_wr (mem_wr), .mem_addr (mem_addr),
      .mem_wdata (mem_wdata), .mem_rdata (mem_rdata), .mem_rvalid (mem_rvalid)
   );

   mem_fill_arbiter #(.NUM_REQ(4), .ADDR_W(16), .DATA_W(16), .WPB(4)) dut4 (
      .clk (clk), .rst (rst), .miss (miss4), .miss_addr (miss_addr4),
      .wr_req (wr_req4), .wr_addr (wr_addr4), .wr_data (wr_data4),
      .wr_ack (wr_ack4), .stall (stall4), .fill_data_we (we4),
      .fill_tag_we (tag4), .fill_word (word4), .fill_data (data4),
      .mem_en (en4), .mem_wr (wr4), .mem_addr (addr4),
      .mem_wdata (wdata4), .mem_rdata (rdata4), .mem_rvalid (rvalid4)
   );

   // Memory models: read data = tag | address, four cycles after issue.
   logic [3:0]  rv_pipe  = '0;
   logic [3:0]  rv_pipe4 = '0;
   logic [15:0] rd_pipe  [4];
   logic [15:0] rd_pipe4 [4];
   logic        rv_inject = 1'b0;

   always @(posedge clk) begin
      rv_pipe     <= {rv_pipe[2:0], mem_en & ~mem_wr};
      rd_pipe[0]  <= 16'hD000 | mem_addr;
      rv_pipe4    <= {rv_pipe4[2:0], en4 & ~wr4};
      rd_pipe4[0] <= 16'hE000 | addr4;
      for (int k = 1; k < 4; k++) begin
         rd_pipe[k]  <= rd_pipe[k-1];
         rd_pipe4[k] <= rd_pipe4[k-1];
      end
   end

   assign mem_rvalid = rv_pipe[3] | rv_inject;
   assign mem_rdata  = rd_pipe[3];
   assign rvalid4    = rv_pipe4[3];
   assign rdata4     = rd_pipe4[3];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      miss   = '0;
      wr_req = '0;
      miss4  = '0;
      repeat (5) tick();
      rst = 1'b0;
      tick();
   endtask

   // Follows one complete fill of channel ch; optionally raises wr_req[0] after the first issue.
   task automatic do_fill(input int ch, input logic [15:0] base, input bit raise_wr);
      int issues, rets, first_iss, last_iss;
      bit done;
      issues = 0; rets = 0; first_iss = -1; last_iss = -1; done = 1'b0;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         tick();
         chk("fill_no_write", 32'({mem_wr, wr_ack}), 32'd0);
         if (mem_en) begin
            chk("fill_addr", 32'(mem_addr), 32'(base) + 32'(2 * issues));
            if (issues == 0) begin
               first_iss = cyc;
               miss_addr[ch*16 +: 16] = 16'hFFFE;
               if (raise_wr) begin
                  wr_req[0] = 1'b1;
                  #1;
                  chk("fill_wr_stall", 32'(stall), 32'h3);
               end
            end
            last_iss = cyc;
            issues++;
         end
         if (fill_data_we != 2'b00) begin
            chk("fill_we", 32'(fill_data_we), 32'(1 << ch));
            chk("fill_word", 32'(fill_word), 32'(rets));
            chk("fill_data", 32'(fill_data), 32'(16'hD000 | (base + 16'(2 * rets))));
            chk("fill_tag", 32'(fill_tag_we), (rets == 7) ? 32'(1 << ch) : 32'd0);
            if (rets == 7) done = 1'b1;
            rets++;
         end else begin
            chk("fill_tag_idle", 32'(fill_tag_we), 32'd0);
         end
      end
      chk("fill_done", 32'(done), 32'd1);
      chk("fill_issues", 32'(issues), 32'd8);
      chk("fill_consec", 32'(last_iss - first_iss), 32'd7);
      miss[ch] = 1'b0;
      #1;
      chk("fill_stall_rel", 32'(stall[ch]), 32'd0);
   endtask

   initial begin
      int  issues, rets;
      bit  done, found;

      rst = 1'b1;
      miss = '0; miss_addr = '0; wr_req = '0; wr_addr = '0; wr_data = '0;
      miss4 = '0; miss_addr4 = '0; wr_req4 = '0; wr_addr4 = '0; wr_data4 = '0;

      // Reset state
      repeat (3) tick();
      chk("rst_ctrl", 32'({mem_en, mem_wr, wr_ack, fill_data_we, fill_tag_we}), 32'd0);
      chk("rst_bus", 32'({mem_addr, fill_data}), 32'd0);
      chk("rst_word", 32'(fill_word), 32'd0);
      chk("rst_dut4", 32'({en4, we4, tag4, wr_ack4}), 32'd0);
      miss = 2'b10;
      #1;
      chk("rst_stall", 32'(stall), 32'h2);
      miss = 2'b00;
      #1;
      chk("rst_stall_clr", 32'(stall), 32'h0);
      repeat (2) tick();
      rst = 1'b0;
      tick();

      // Single miss on ch0 at 0x0046
      miss_addr[15:0]  = 16'h0046;
      miss_addr[31:16] = 16'h1234;
      miss = 2'b01;
      #1;
      chk("m0_stall", 32'(stall), 32'h1);
      do_fill(0, 16'h0040, 1'b0);

      // Stray read-valid while idle produces no strobes
      tick();
      rv_inject = 1'b1;
      tick();
      rv_inject = 1'b0;
      chk("stray_rvalid", 32'({fill_data_we, fill_tag_we, mem_en}), 32'd0);

      // Both channels miss after reset: ch0 then ch1, twice
      do_reset();
      miss_addr = {16'h0212, 16'h0100};
      miss = 2'b11;
      do_fill(0, 16'h0100, 1'b0);
      do_fill(1, 16'h0210, 1'b0);
      tick();
      miss_addr = {16'h0520, 16'h0538};
      miss = 2'b11;
      do_fill(0, 16'h0530, 1'b0);
      do_fill(1, 16'h0520, 1'b0);

      // Write on ch1 and miss on ch0 together: write goes first
      tick();
      wr_addr[31:16]  = 16'h1000;
      wr_data[31:16]  = 16'hBEEF;
      miss_addr[15:0] = 16'h0046;
      wr_req = 2'b10;
      miss   = 2'b01;
      tick();
      chk("wr_ctrl", 32'({mem_en, mem_wr}), 32'h3);
      chk("wr_addr", 32'(mem_addr), 32'h1000);
      chk("wr_data", 32'(mem_wdata), 32'hBEEF);
      chk("wr_ack", 32'(wr_ack), 32'h2);
      chk("wr_no_fill", 32'(fill_data_we), 32'h0);
      wr_req = 2'b00;
      #1;
      chk("wr_stall", 32'(stall), 32'h1);
      do_fill(0, 16'h0040, 1'b0);

      // Reset during a fill once three words have returned
      tick();
      miss_addr[15:0] = 16'h0305;
      miss = 2'b01;
      found = 1'b0;
      for (int cyc = 0; cyc < 30 && !found; cyc++) begin
         tick();
         if (fill_data_we[0] && fill_word == 3'd2) found = 1'b1;
      end
      chk("abort_reach", 32'(found), 32'd1);
      rst  = 1'b1;
      miss = 2'b00;
      for (int cyc = 0; cyc < 12; cyc++) begin
         tick();
         if (cyc == 2) rst = 1'b0;
         chk("abort_quiet", 32'({fill_data_we, fill_tag_we, mem_en}), 32'd0);
      end
      miss = 2'b01;
      do_fill(0, 16'h0300, 1'b0);

      // Write from ch0 raised during a ch1 fill waits for the fill to finish
      tick();
      wr_addr[15:0]    = 16'h2000;
      wr_data[15:0]    = 16'h1234;
      miss_addr[31:16] = 16'h0400;
      miss = 2'b10;
      do_fill(1, 16'h0400, 1'b1);
      tick();
      chk("late_wr_ack", 32'(wr_ack), 32'h1);
      chk("late_wr_ctrl", 32'({mem_en, mem_wr}), 32'h3);
      chk("late_wr_addr", 32'(mem_addr), 32'h2000);
      chk("late_wr_data", 32'(mem_wdata), 32'h1234);
      wr_req = 2'b00;
      tick();

      // Four channels, four-word blocks: miss on ch3 at 0x00F6
      miss_addr4[63:48] = 16'h00F6;
      miss4 = 4'b1000;
      issues = 0; rets = 0; done = 1'b0;
      for (int cyc = 0; cyc < 30 && !done; cyc++) begin
         tick();
         if (en4) begin
            chk("q_addr", 32'(addr4), 32'h00F0 + 32'(2 * issues));
            issues++;
         end
         if (we4 != 4'b0000) begin
            chk("q_we", 32'(we4), 32'h8);
            chk("q_word", 32'(word4), 32'(rets));
            chk("q_data", 32'(data4), 32'hE0F0 + 32'(2 * rets));
            chk("q_tag", 32'(tag4), (rets == 3) ? 32'h8 : 32'h0);
            if (rets == 3) done = 1'b1;
            rets++;
         end
      end
      miss4 = 4'b0000;
      chk("q_done", 32'(done), 32'd1);
      chk("q_issues", 32'(issues), 32'd4);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
